dbus_arbiter: RTL and testbench
===============================

Name: dbus_arbiter

Overview:
- Shares one synchronous-read, word-wide data RAM port between two bus masters.
- m0 is the CPU data port (load/store path). m1 is the UART loader/debug master that writes program images and reads back memory.
- Sequences each access through a fixed issue/wait/respond schedule with a registered one-cycle ack, so neither master sees RAM read latency directly.
- Sits between the masters and the data RAM. The CPU-side stall logic uses m0_ack to know when a load/store completes.

Parameters:
- ADDR_W, 10, RAM word-address width (RAM depth = 2^ADDR_W words).
- FIXED_PRIO, 0, 0 = round-robin between m0/m1; 1 = m0 always wins ties.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- m0_req  input  1  CPU request; held with fields stable until m0_ack
- m0_we  input  1  1 = write, 0 = read
- m0_addr  input  32  byte address; bits [1:0] ignored
- m0_wdata  input  32  write data
- m0_ack  output  1  one-cycle completion pulse
- m0_rdata  output  32  read data, valid while m0_ack=1
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata: same as m0_*, for the loader master
- mem_en  output  1  RAM access enable
- mem_we  output  1  RAM write enable (only with mem_en)
- mem_addr  output  ADDR_W  RAM word address
- mem_wdata  output  32  RAM write data
- mem_rdata  input  32  RAM read data, valid the cycle after mem_en with mem_we=0
- busy  output  1  1 whenever state != IDLE
- grant  output  1  owner of the current/last transaction (0 = m0, 1 = m1)

Behaviour:
- Reset (async, any state): state=IDLE; m0_ack=m1_ack=0; m0_rdata=m1_rdata=0; mem_en=mem_we=0; mem_addr=0; mem_wdata=0; grant=0; last_grant=1 (so m0 wins the first tie).
- All outputs are registered. There is no combinational path from req to mem_* or ack.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE: req is sampled only in this state.
  - Only m0_req: grant m0. Only m1_req: grant m1.
  - Both, FIXED_PRIO=0: grant the master that did not win last_grant. FIXED_PRIO=1: grant m0.
  - On grant: latch we, addr[ADDR_W+1:2] and wdata of the winner; set grant; update last_grant; go to ISSUE.
  - No req: stay in IDLE with mem_en=0.
- ISSUE: mem_en=1, mem_we=latched we, mem_addr/mem_wdata=latched values for exactly one cycle; go to WAIT.
- WAIT: mem_en=0.
  - Read: capture mem_rdata into the granted master's rdata register.
  - Write: rdata registers unchanged.
  - Go to RESP.
- RESP: granted master's ack=1 for exactly one cycle; the other ack stays 0; go to IDLE.
- Latency: req high at clock edge N (state IDLE) -> mem_en high in cycle N+1 -> ack high in cycle N+3. Throughput is one transaction per 4 cycles.
- Masters must keep req and all fields stable from assertion until the cycle ack=1.
  - A master still holding req in the IDLE cycle after its RESP is treated as a new transaction.
  - With both masters continuously requesting under round-robin, grants strictly alternate: m0, m1, m0, ...
- A req asserted or deasserted by the non-granted master during ISSUE/WAIT/RESP is ignored until the next IDLE.
- Address bits above ADDR_W+1 are discarded, so addresses wrap modulo RAM size. Byte offset bits [1:0] are discarded; sub-word handling is the master's responsibility.
- mX_rdata holds its last captured value between transactions.
- Reset mid-transaction (any state): the transaction is abandoned and no ack is issued. A write already issued in ISSUE may have committed to RAM; otherwise RAM is untouched.

Test Plan:
1. Read: preload RAM word 5 = 0xDEADBEEF; m0 read addr 0x14 -> mem_en=1, mem_we=0, mem_addr=5 at N+1; m0_ack=1, m0_rdata=0xDEADBEEF at N+3; m1_ack stays 0.
2. Write then read: m1 write addr 0x20 data 0x12345678 -> mem_we=1, mem_addr=8 at N+1, m1_ack at N+3; m0 read 0x20 -> m0_rdata=0x12345678.
3. Round-robin: FIXED_PRIO=0, both reqs held for 4 transactions -> grants m0, m1, m0, m1, with acks 4 cycles apart; after reset the first tie goes to m0.
4. Fixed priority: FIXED_PRIO=1, both reqs held for 3 transactions -> m0 granted all 3; m1 is granted only once m0_req drops.
5. Reset: assert rst during WAIT of an m0 read -> next cycle state=IDLE, busy=0, no m0_ack pulse ever; a subsequent m1 request completes normally in 3 cycles.
6. Wrap/offset: ADDR_W=10, m0 read 0x0000_1007 -> mem_addr=1 (upper bits and [1:0] dropped).

Source files
------------

// File: rtl/dbus_arbiter.sv
// Two-master arbiter for a single synchronous-read data RAM port.
// Each access runs IDLE -> ISSUE -> WAIT -> RESP, and every output comes from a flop.
module dbus_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [31:0]       m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic              m0_ack,
    output logic [31:0]       m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [31:0]       m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic              m1_ack,
    output logic [31:0]       m1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy,
    output logic              grant
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t r_state;
    state_t w_nextState;
    logic   r_lastGrant;
    logic   r_we;
    logic   w_start;
    logic   w_pick;

    logic [ADDR_W-1:0] w_addr;
    logic              w_unusedAddrBits;

    assign w_addr = w_pick ? m1_addr[ADDR_W+1:2] : m0_addr[ADDR_W+1:2];
    assign w_unusedAddrBits = ^{m0_addr[31:ADDR_W+2], m0_addr[1:0],
                                m1_addr[31:ADDR_W+2], m1_addr[1:0]};

    // Requests are only looked at in IDLE; a tie goes to whoever did not win last time.
    always_comb begin
        w_nextState = r_state;
        w_start     = 1'b0;
        w_pick      = 1'b0;
        case (r_state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    w_start     = 1'b1;
                    w_nextState = ISSUE;
                    if (m0_req && m1_req)
                        w_pick = (FIXED_PRIO != 0) ? 1'b0 : ~r_lastGrant;
                    else
                        w_pick = m1_req;
                end
            end
            ISSUE:   w_nextState = WAIT;
            WAIT:    w_nextState = RESP;
            RESP:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_nextState;
    end

    // The RAM strobe is loaded on the grant edge so it is high exactly during ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            m0_ack      <= 1'b0;
            m1_ack      <= 1'b0;
            m0_rdata    <= '0;
            m1_rdata    <= '0;
            busy        <= 1'b0;
            grant       <= 1'b0;
            r_lastGrant <= 1'b1;
            r_we        <= 1'b0;
        end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            busy   <= (w_nextState != IDLE);
            if (w_start) begin
                grant       <= w_pick;
                r_lastGrant <= w_pick;
                r_we        <= w_pick ? m1_we : m0_we;
                mem_en      <= 1'b1;
                mem_we      <= w_pick ? m1_we : m0_we;
                mem_addr    <= w_addr;
                mem_wdata   <= w_pick ? m1_wdata : m0_wdata;
            end
            // Read data lands in WAIT; capture it on the same edge that raises ack.
            if (r_state == WAIT) begin
                if (!r_we) begin
                    if (grant)
                        m1_rdata <= mem_rdata;
                    else
                        m0_rdata <= mem_rdata;
                end
                if (grant)
                    m1_ack <= 1'b1;
                else
                    m0_ack <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Bench for dbus_arbiter: table of single transactions plus hand sequences for
// round-robin, fixed priority and mid-transaction reset, checked through an ack scoreboard.
module tb_dbus_arbiter;

    localparam int ADDR_W = 10;

    typedef struct {
        logic        master;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        logic        master;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [9:0]  expAddr;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic m0Req, m0We, m1Req, m1We;
    logic [31:0] m0Addr, m0Wdata, m1Addr, m1Wdata;

    logic        m0Ack, m1Ack, memEn, memWe, busy, grant;
    logic [31:0] m0Rdata, m1Rdata, memWdata, memRdata;
    logic [9:0]  memAddr;

    logic        fpM0Ack, fpM1Ack, fpMemEn, fpMemWe, fpBusy, fpGrant;
    logic [31:0] fpM0Rdata, fpM1Rdata, fpMemWdata, fpMemRdata;
    logic [9:0]  fpMemAddr;

    logic        bdEn;
    logic [9:0]  bdAddr;
    logic [31:0] bdData;

    logic [31:0] ram     [0:1023];
    logic [31:0] fpRam   [0:1023];
    logic [31:0] refMem  [0:1023];
    logic [31:0] lastRd  [0:1];
    exp_t        sbQ[$];
    vec_t        vecs[9];

    int total = 0;
    int bad   = 0;

    dbus_arbiter #(.ADDR_W(ADDR_W), .FIXED_PRIO(0)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0Req), .m0_we(m0We), .m0_addr(m0Addr), .m0_wdata(m0Wdata),
        .m0_ack(m0Ack), .m0_rdata(m0Rdata),
        .m1_req(m1Req), .m1_we(m1We), .m1_addr(m1Addr), .m1_wdata(m1Wdata),
        .m1_ack(m1Ack), .m1_rdata(m1Rdata),
        .mem_en(memEn), .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata),
        .mem_rdata(memRdata), .busy(busy), .grant(grant)
    );

    dbus_arbiter #(.ADDR_W(ADDR_W), .FIXED_PRIO(1)) dutFp (
        .clk(clk), .rst(rst),
        .m0_req(m0Req), .m0_we(m0We), .m0_addr(m0Addr), .m0_wdata(m0Wdata),
        .m0_ack(fpM0Ack), .m0_rdata(fpM0Rdata),
        .m1_req(m1Req), .m1_we(m1We), .m1_addr(m1Addr), .m1_wdata(m1Wdata),
        .m1_ack(fpM1Ack), .m1_rdata(fpM1Rdata),
        .mem_en(fpMemEn), .mem_we(fpMemWe), .mem_addr(fpMemAddr), .mem_wdata(fpMemWdata),
        .mem_rdata(fpMemRdata), .busy(fpBusy), .grant(fpGrant)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAMs behind each arbiter, with a backdoor port for preloading.
    always @(posedge clk) begin
        if (bdEn) begin
            ram[bdAddr]   <= bdData;
            fpRam[bdAddr] <= bdData;
        end else begin
            if (memEn) begin
                if (memWe) ram[memAddr] <= memWdata;
                else       memRdata <= ram[memAddr];
            end
            if (fpMemEn) begin
                if (fpMemWe) fpRam[fpMemAddr] <= fpMemWdata;
                else         fpMemRdata <= fpRam[fpMemAddr];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Every ack pulse of the round-robin arbiter is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (m0Ack || m1Ack)) begin
            if (m0Ack && m1Ack) begin
                checkOutput("both acks high", {m0Ack, m1Ack}, 2'b01);
            end else if (sbQ.size() == 0) begin
                checkOutput("unexpected ack", {m0Ack, m1Ack}, 2'b00);
            end else begin
                e = sbQ.pop_front();
                checkOutput("ack master", m1Ack, e.master);
                checkOutput("ack rdata", m1Ack ? m1Rdata : m0Rdata, e.rdata);
            end
        end
    end

    task automatic pushExpect(input logic master, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata);
        logic [9:0] idx;
        idx = addr[11:2];
        if (we) refMem[idx] = wdata;
        else    lastRd[master] = refMem[idx];
        sbQ.push_back('{master: master, rdata: lastRd[master]});
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        bdEn = 1'b1; bdAddr = a; bdData = d;
        refMem[a] = d;
        @(negedge clk);
        bdEn = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        m0Req = 1'b0; m1Req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        lastRd[0] = '0;
        lastRd[1] = '0;
    endtask

    task automatic driveMaster(input logic master, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata);
        if (master) begin
            m1Req = 1'b1; m1We = we; m1Addr = addr; m1Wdata = wdata;
        end else begin
            m0Req = 1'b1; m0We = we; m0Addr = addr; m0Wdata = wdata;
        end
    endtask

    task automatic waitAck(output int n, output logic who);
        n = 0;
        who = 1'bx;
        while (n < 12) begin
            @(negedge clk);
            n++;
            if (m0Ack || m1Ack) begin
                who = m1Ack;
                break;
            end
        end
    endtask

    // One isolated transaction from IDLE: check the ISSUE cycle, WAIT, and the ack latency.
    task automatic applyStimulus(input vec_t v);
        int   n;
        logic who;
        @(negedge clk);
        driveMaster(v.master, v.we, v.addr, v.wdata);
        pushExpect(v.master, v.we, v.addr, v.wdata);
        @(negedge clk);
        checkOutput("issue mem_en", memEn, 1'b1);
        checkOutput("issue mem_we", memWe, v.we);
        checkOutput("issue mem_addr", memAddr, v.expAddr);
        checkOutput("issue grant", grant, v.master);
        checkOutput("issue busy", busy, 1'b1);
        if (v.we) checkOutput("issue mem_wdata", memWdata, v.wdata);
        @(negedge clk);
        checkOutput("wait mem_en", memEn, 1'b0);
        waitAck(n, who);
        checkOutput("ack latency", n + 2, 3);
        if (v.master) m1Req = 1'b0;
        else          m0Req = 1'b0;
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int   n;
        int   fp0, fp1, fpM1Cycle;
        logic who;
        logic ackSeen;

        vecs[0] = '{master: 1'b0, we: 1'b0, addr: 32'h0000_0014, wdata: 32'h0,         expAddr: 10'd5};
        vecs[1] = '{master: 1'b1, we: 1'b1, addr: 32'h0000_0020, wdata: 32'h1234_5678, expAddr: 10'd8};
        vecs[2] = '{master: 1'b0, we: 1'b0, addr: 32'h0000_0020, wdata: 32'h0,         expAddr: 10'd8};
        vecs[3] = '{master: 1'b1, we: 1'b0, addr: 32'h0000_0014, wdata: 32'h0,         expAddr: 10'd5};
        vecs[4] = '{master: 1'b0, we: 1'b1, addr: 32'h0000_0004, wdata: 32'hA5A5_A5A5, expAddr: 10'd1};
        vecs[5] = '{master: 1'b0, we: 1'b0, addr: 32'h0000_1007, wdata: 32'h0,         expAddr: 10'd1};
        vecs[6] = '{master: 1'b1, we: 1'b1, addr: 32'h0000_0FFC, wdata: 32'h0000_0001, expAddr: 10'h3FF};
        vecs[7] = '{master: 1'b1, we: 1'b0, addr: 32'hFFFF_FFFF, wdata: 32'h0,         expAddr: 10'h3FF};
        vecs[8] = '{master: 1'b0, we: 1'b1, addr: 32'h0000_0018, wdata: 32'hCAFE_F00D, expAddr: 10'd6};

        rst = 1'b1;
        bdEn = 1'b0; bdAddr = '0; bdData = '0;
        m0Req = 1'b0; m0We = 1'b0; m0Addr = '0; m0Wdata = '0;
        m1Req = 1'b0; m1We = 1'b0; m1Addr = '0; m1Wdata = '0;
        lastRd[0] = '0; lastRd[1] = '0;
        #12;
        checkOutput("reset mem_en", memEn, 1'b0);
        checkOutput("reset mem_we", memWe, 1'b0);
        checkOutput("reset mem_addr", memAddr, 10'd0);
        checkOutput("reset mem_wdata", memWdata, 32'h0);
        checkOutput("reset m0_ack", m0Ack, 1'b0);
        checkOutput("reset m1_ack", m1Ack, 1'b0);
        checkOutput("reset m0_rdata", m0Rdata, 32'h0);
        checkOutput("reset m1_rdata", m1Rdata, 32'h0);
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset grant", grant, 1'b0);
        doReset();

        preload(10'd5, 32'hDEAD_BEEF);
        for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);
        checkOutput("m0_rdata held after write", m0Rdata, 32'hA5A5_A5A5);

        // Both masters hold requests: grants alternate, first tie after reset to m0.
        doReset();
        @(negedge clk);
        driveMaster(1'b0, 1'b0, 32'h0000_0014, 32'h0);
        driveMaster(1'b1, 1'b0, 32'h0000_0020, 32'h0);
        for (int k = 0; k < 4; k++) pushExpect(k[0], 1'b0, k[0] ? 32'h20 : 32'h14, 32'h0);
        for (int k = 0; k < 4; k++) begin
            waitAck(n, who);
            checkOutput($sformatf("rr ack owner %0d", k), who, k[0]);
            checkOutput($sformatf("rr grant %0d", k), grant, k[0]);
            checkOutput($sformatf("rr spacing %0d", k), n, (k == 0) ? 3 : 4);
        end
        m0Req = 1'b0; m1Req = 1'b0;

        // Fixed-priority instance keeps m0 until m0 lets go.
        doReset();
        @(negedge clk);
        driveMaster(1'b0, 1'b0, 32'h0000_0014, 32'h0);
        driveMaster(1'b1, 1'b0, 32'h0000_0020, 32'h0);
        for (int k = 0; k < 4; k++) pushExpect(k[0], 1'b0, k[0] ? 32'h20 : 32'h14, 32'h0);
        fp0 = 0; fp1 = 0; fpM1Cycle = 0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (fpM0Ack) fp0++;
            if (fpM1Ack) begin
                fp1++;
                if (fpM1Cycle == 0) fpM1Cycle = c;
            end
            if (c == 11) begin
                checkOutput("fp m0 acks while tied", fp0, 3);
                checkOutput("fp m1 acks while tied", fp1, 0);
                m0Req = 1'b0;
            end
        end
        checkOutput("fp m1 ack cycle", fpM1Cycle, 15);
        checkOutput("fp grant to m1", fpGrant, 1'b1);
        m1Req = 1'b0;

        // Reset during WAIT of an m0 read abandons it without an ack.
        @(negedge clk);
        driveMaster(1'b0, 1'b0, 32'h0000_0014, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abort busy", busy, 1'b0);
        checkOutput("abort mem_en", memEn, 1'b0);
        checkOutput("abort m0_ack", m0Ack, 1'b0);
        checkOutput("abort m0_rdata", m0Rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        m0Req = 1'b0;
        lastRd[0] = '0; lastRd[1] = '0;
        ackSeen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (m0Ack) ackSeen = 1'b1;
        end
        checkOutput("no ack after abort", ackSeen, 1'b0);
        applyStimulus('{master: 1'b1, we: 1'b0, addr: 32'h0000_0020, wdata: 32'h0, expAddr: 10'd8});

        repeat (3) @(negedge clk);
        checkOutput("scoreboard drained", sbQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
